// File: rtl/gcd_miter_p_if.sv
// gcd_miter_p_if: transaction bus for the GCD miter.
// master drives start/Ain/Bin; slave returns busy, done, nequiv, timeout, Out_1, Out_2.
interface gcd_miter_p_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] Ain, Bin, Out_1, Out_2;
  logic busy, done, nequiv, timeout;
  modport master(output start, Ain, Bin, input busy, done, nequiv, timeout, Out_1, Out_2);
  modport slave(input start, Ain, Bin, output busy, done, nequiv, timeout, Out_1, Out_2);
endinterface

// File: rtl/gcd_miter_p.sv
// gcd_miter_p: lockstep equivalence miter of two subtractive GCD engines with start/done handshake.
// Ports: clk, rst (async, active high), bus (slave): start/Ain/Bin in; busy, done, nequiv, timeout, Out_1, Out_2 out.
module gcd_miter_p #(
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 1024,
  parameter int ENG2_SWAP = 1
) (
  input logic clk,
  input logic rst,
  gcd_miter_p_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam bit SW = ENG2_SWAP != 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a1, b1, a2, b2, o1, o2, a1_n, b1_n, a2_n, b2_n;
  logic v1, v2, neq, tmo, load, zero, hit, fin;
  logic [CW-1:0] cnt;
  always_comb begin
    load = state == IDLE && bus.start;
    zero = bus.Ain == '0 || bus.Bin == '0;
    fin = v1 && v2;
    // the edge that would bring the counter to TIMEOUT
    hit = cnt == CW'(TIMEOUT - 1);
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? ((fin || hit) ? DONE : RUN) : IDLE;
    a1_n = a1 > b1 ? a1 - b1 : a1;
    b1_n = a1 < b1 ? b1 - a1 : b1;
    a2_n = a2 > b2 ? a2 - b2 : (a2 < b2 && SW) ? b2 : a2;
    b2_n = a2 < b2 ? (SW ? a2 : b2 - a2) : b2;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {a1, b1, a2, b2, o1, o2} <= '0;
      {v1, v2, neq, tmo} <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        a1 <= bus.Ain;
        b1 <= bus.Bin;
        a2 <= bus.Ain;
        b2 <= bus.Bin;
        v1 <= zero;
        v2 <= zero;
        o1 <= zero ? bus.Ain | bus.Bin : o1;
        o2 <= zero ? bus.Ain | bus.Bin : o2;
        cnt <= '0;
        neq <= 1'b0;
        tmo <= 1'b0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (!v1) begin
          a1 <= a1_n;
          b1 <= b1_n;
          if (a1 == b1) begin
            o1 <= a1;
            v1 <= 1'b1;
          end
        end
        if (!v2) begin
          a2 <= a2_n;
          b2 <= b2_n;
          if (a2 == b2) begin
            o2 <= a2;
            v2 <= 1'b1;
          end
        end
        // completion takes priority over an expiring counter
        if (fin) neq <= o1 != o2;
        else if (hit) begin
          tmo <= 1'b1;
          neq <= 1'b0;
        end
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.nequiv = neq;
  assign bus.timeout = tmo;
  assign bus.Out_1 = o1;
  assign bus.Out_2 = o2;
endmodule

// File: tb/tb_gcd_miter_p.sv
// tb_gcd_miter_p: directed and randomised checks of gcd_miter_p against a Euclid reference.
module tb_gcd_miter_p;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  gcd_miter_p_if #(.WIDTH(8)) i8();
  gcd_miter_p_if #(.WIDTH(8)) it();
  gcd_miter_p_if #(.WIDTH(6)) i6a();
  gcd_miter_p_if #(.WIDTH(6)) i6b();
  gcd_miter_p #(.WIDTH(8), .TIMEOUT(1024), .ENG2_SWAP(1)) u8(.clk(clk), .rst(rst), .bus(i8));
  gcd_miter_p #(.WIDTH(8), .TIMEOUT(100), .ENG2_SWAP(1)) ut(.clk(clk), .rst(rst), .bus(it));
  gcd_miter_p #(.WIDTH(6), .TIMEOUT(1024), .ENG2_SWAP(0)) u6a(.clk(clk), .rst(rst), .bus(i6a));
  gcd_miter_p #(.WIDTH(6), .TIMEOUT(1024), .ENG2_SWAP(1)) u6b(.clk(clk), .rst(rst), .bus(i6b));
  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    i8.start = 1'b1; i8.Ain = a; i8.Bin = b;
    it.start = 1'b1; it.Ain = a; it.Bin = b;
    @(negedge clk);
    i8.start = 1'b0;
    it.start = 1'b0;
  endtask
  task automatic wait8(output int lat, output int bcy);
    lat = 1; bcy = 0;
    while (!i8.done && lat < 3000) begin
      if (i8.busy) bcy++;
      @(negedge clk);
      lat++;
    end
    if (i8.busy) bcy++;
  endtask
  task automatic waitt(output int lat);
    lat = 1;
    while (!it.done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic settle();
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int lat, bcy, g, da, db, cyc;
    logic [5:0] ra, rb;
    {i8.start, i8.Ain, i8.Bin, it.start, it.Ain, it.Bin} = '0;
    {i6a.start, i6a.Ain, i6a.Bin, i6b.start, i6b.Ain, i6b.Bin} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", i8.busy, 0);
    chk("rst_done", i8.done, 0);
    chk("rst_out", {i8.Out_1, i8.Out_2}, 0);
    chk("rst_flags", {i8.nequiv, i8.timeout}, 0);
    launch8(8'd12, 8'd18);
    wait8(lat, bcy);
    chk("g12_18_lat", lat, 7);
    chk("g12_18_busy", bcy, 7);
    chk("g12_18_out", {i8.Out_1, i8.Out_2}, {8'd6, 8'd6});
    chk("g12_18_flags", {i8.nequiv, i8.timeout}, 0);
    @(negedge clk);
    chk("g12_18_idle", {i8.busy, i8.done}, 0);
    chk("g12_18_hold", {i8.Out_1, i8.Out_2}, {8'd6, 8'd6});
    settle();
    launch8(8'd0, 8'd45);
    wait8(lat, bcy);
    chk("z0_45_lat", lat, 2);
    chk("z0_45_out", {i8.Out_1, i8.Out_2, 7'd0, i8.nequiv}, {8'd45, 8'd45, 8'd0});
    settle();
    launch8(8'd0, 8'd0);
    wait8(lat, bcy);
    chk("z0_0_lat", lat, 2);
    chk("z0_0_out", {i8.Out_1, i8.Out_2}, 0);
    settle();
    launch8(8'd255, 8'd1);
    waitt(lat);
    chk("to_lat", lat, 101);
    chk("to_flags", {it.timeout, it.nequiv}, 2'b10);
    wait8(lat, bcy);
    chk("nto_lat", lat, 157);
    chk("nto_out", {i8.Out_1, i8.Out_2}, {8'd1, 8'd1});
    chk("nto_flags", {i8.timeout, i8.nequiv}, 0);
    settle();
    @(negedge clk);
    force u8.o2 = 8'd7;
    launch8(8'd5, 8'd5);
    wait8(lat, bcy);
    chk("flt_lat", lat, 3);
    chk("flt_neq", i8.nequiv, 1);
    @(negedge clk);
    release u8.o2;
    @(negedge clk);
    chk("flt_hold", i8.nequiv, 1);
    launch8(8'd9, 8'd6);
    chk("flt_clear", i8.nequiv, 0);
    wait8(lat, bcy);
    chk("flt_clean", {i8.Out_1, i8.Out_2, 7'd0, i8.nequiv}, {8'd3, 8'd3, 8'd0});
    settle();
    launch8(8'd200, 8'd150);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_out", {i8.Out_1, i8.Out_2}, 0);
    chk("mrst_ctl", {i8.busy, i8.done, i8.nequiv, i8.timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    da = 0;
    repeat (20) begin
      @(negedge clk);
      if (i8.done) da++;
    end
    chk("mrst_nodone", da, 0);
    launch8(8'd200, 8'd150);
    wait8(lat, bcy);
    chk("mrst_out2", {i8.Out_1, i8.Out_2}, {8'd50, 8'd50});
    settle();
    for (int k = 0; k < 500; k++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      g = gcd(int'(ra), int'(rb));
      @(negedge clk);
      i6a.start = 1'b1; i6a.Ain = ra; i6a.Bin = rb;
      i6b.start = 1'b1; i6b.Ain = ra; i6b.Bin = rb;
      da = 0; db = 0; cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        // random start while both are busy must be ignored; never offered in IDLE
        i6a.start = $urandom_range(0, 1) == 1 && i6a.busy && i6b.busy;
        i6b.start = i6a.start;
        if (i6a.done) begin
          da++;
          chk("r6a_out", {i6a.Out_1, i6a.Out_2}, {6'(g), 6'(g)});
          chk("r6a_flags", {i6a.nequiv, i6a.timeout}, 0);
        end
        if (i6b.done) begin
          db++;
          chk("r6b_out", {i6b.Out_1, i6b.Out_2}, {6'(g), 6'(g)});
          chk("r6b_flags", {i6b.nequiv, i6b.timeout}, 0);
        end
      end while ((i6a.busy || i6b.busy) && cyc < 1000);
      i6a.start = 1'b0;
      i6b.start = 1'b0;
      chk("r6_bound", cyc < 1000, 1);
      chk("r6_dones", {da, db}, {32'd1, 32'd1});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gcd_miter_p.md
Name: gcd_miter_p

Overview:
- Parametrised lockstep equivalence miter for two GCD engines. It is the next generation of the fixed 6-bit, free-running fast/slow GCD miter.
- Both engines run on one operand pair per transaction, and the block reports one verdict per transaction.
- It adds over the previous generation:
  - configurable width;
  - a selectable algorithm for engine 2;
  - a start/done handshake;
  - zero-operand short-circuit;
  - a bounded-run timeout.
- It sits under the formal/simulation harness as the device under check. Arbitrary Ain/Bin drive it, and nequiv is the property output.

Parameters:
- WIDTH, 8, operand and result width in bits.
- TIMEOUT, 1024, maximum RUN cycles before the transaction aborts; the counter is $clog2(TIMEOUT+1) bits wide.
- ENG2_SWAP, 1, engine 2 algorithm: 1 = swap-then-subtract (A<B swaps A and B), 0 = subtract (identical to engine 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active high.
- start  input  1  request a transaction; sampled only in IDLE.
- Ain  input  WIDTH  operand A; sampled with start.
- Bin  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; the verdict is valid in that cycle.
- nequiv  output  1  engines completed with different results.
- timeout  output  1  transaction aborted by TIMEOUT.
- Out_1  output  WIDTH  engine 1 result.
- Out_2  output  WIDTH  engine 2 result.

Behaviour:
- Reset (async, rst=1): all of the following return to their reset values immediately.
  - FSM returns to IDLE.
  - busy, done, nequiv and timeout are 0.
  - Out_1 and Out_2 are 0.
  - Engine A/B registers, valid_1, valid_2 and the cycle counter are 0.
  - Reset mid-transaction discards the transaction; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a clock edge with start=1. At that edge:
    - both engines load A<=Ain, B<=Bin;
    - valid_1 and valid_2 are cleared;
    - the counter clears;
    - nequiv and timeout clear.
  - Zero short-circuit applies at load: if Ain==0 or Bin==0, both engines set valid=1 and Out=Ain|Bin at the load edge. Result 0 when both are 0.
  - RUN, per edge:
    - the counter increments;
    - each engine with valid=0 takes one step;
    - an engine with valid=1 holds A, B and Out (stall, so the first finisher waits for the other).
  - Engine step rules:
    - A>B: A<=A-B.
    - A<B, engine 1: B<=B-A.
    - A<B, engine 2: ENG2_SWAP=1 gives A<=B and B<=A; ENG2_SWAP=0 gives B<=B-A.
    - A==B: Out<=A, valid<=1.
  - Subtractions never underflow because they are guarded by the comparison. Width stays WIDTH with no carry.
  - RUN -> DONE when valid_1 and valid_2 are both 1, sampled at an edge. At that edge nequiv<=(Out_1!=Out_2).
  - RUN -> DONE on timeout: when the counter reaches TIMEOUT while either valid is 0. At that edge timeout<=1 and nequiv<=0.
  - If completion and timeout occur at the same edge, completion wins: timeout=0.
  - DONE lasts one cycle, with done=1 and busy=1, then returns to IDLE.
- Output holding: nequiv, timeout, Out_1 and Out_2 hold until the next accepted start.
- start handling: start in RUN or DONE is ignored; it is not queued. start is a level, so start held high re-launches directly from IDLE after DONE.
- Latency: done is asserted N+2 cycles after the start edge.
  - N = number of step edges for the slower engine, including its A==B edge.
  - A zero operand gives the minimum latency of 2.

Test Plan:
- WIDTH=8, ENG2_SWAP=1, start with Ain=12, Bin=18 -> engine 1 valid 3 edges after load, engine 2 valid 5 edges after load; done pulses 7 cycles after the start edge; Out_1=Out_2=6, nequiv=0, timeout=0; busy spans the 7 cycles.
- Ain=0, Bin=45 -> done 2 cycles after start; Out_1=Out_2=45, nequiv=0. Ain=0, Bin=0 -> Out_1=Out_2=0.
- Ain=255, Bin=1, TIMEOUT=100 -> done with timeout=1 and nequiv=0 after 100 RUN cycles. Same stimulus with TIMEOUT=1024 -> Out_1=Out_2=1, timeout=0.
- Fault injection: force engine 2 Out to 7 when Ain=Bin=5 -> nequiv=1 in the done cycle and held afterwards; the next clean start clears nequiv at the load edge.
- Assert rst mid-RUN (Ain=200, Bin=150, 2 cycles in) -> outputs 0 immediately with no done pulse. A new start after release with Ain=200, Bin=150 -> Out=50.
- Randomised WIDTH=6, ENG2_SWAP in {0,1}, 500 operand pairs, start toggling during RUN -> exactly one done per accepted start; results match a reference GCD; nequiv is never 1.
